ifu_btb: RTL and testbench
==========================

IFU_BTB -- requirements
Module: ifu_btb

Interface
- REQ-001: The module SHALL have one clock and an asynchronous, active-low reset.
- REQ-002: Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: Port `rst_n`, input, 1 bit: asynchronous, active-low reset.
- REQ-004: Port `lookup_valid_i`, input, 1 bit: the fetch stage presents a PC this cycle.
- REQ-005: Port `lookup_pc_i`, input, `INST_ADDR_WIDTH` bits: the fetch PC to predict.
- REQ-006: Port `stall_i`, input, 1 bit: fetch stalled; prediction outputs hold.
- REQ-007: Port `flush_i`, input, 1 bit: invalidate every entry (FENCE, context change).
- REQ-008: Port `btb_update_i`, input, 1 bit: install or replace an entry (driven by the execute-stage BRU).
- REQ-009: Port `btb_update_pc_i`, input, `INST_ADDR_WIDTH` bits: the JALR instruction address.
- REQ-010: Port `btb_update_target_i`, input, `INST_ADDR_WIDTH` bits: the resolved JALR target.
- REQ-011: Port `pred_hit_o`, output, 1 bit: registered prediction valid.
- REQ-012: Port `pred_target_o`, output, `INST_ADDR_WIDTH` bits: registered predicted target.
- REQ-013: Port `pred_pc_o`, output, `INST_ADDR_WIDTH` bits: the PC that the current prediction belongs to.

Function
- REQ-014: Organisation SHALL be direct-mapped, `BTB_ENTRIES` = 16 entries; each entry holds valid (1 bit), tag (`BTB_TAG_W` = 26 bits) and target (32 bits).
- REQ-015: Index SHALL be pc[5:2] and tag SHALL be pc[31:6]; pc[1:0] is ignored.
- REQ-016: Lookup latency SHALL be 1 cycle: when `lookup_valid_i` is high and `stall_i` is low, the next edge registers:
  - `pred_hit_o` = valid & tag match;
  - `pred_target_o` = the entry target on a hit, otherwise 0;
  - `pred_pc_o` = `lookup_pc_i`.
- REQ-017: `lookup_valid_i` low with `stall_i` low SHALL register `pred_hit_o`=0, with `pred_target_o` and `pred_pc_o` unchanged.
- REQ-018: `stall_i` high SHALL hold all three outputs; updates and flush still proceed.
- REQ-019: `btb_update_i` high SHALL write valid=1, tag and target into the indexed entry at the next edge, unconditionally replacing any occupant (alias eviction).
- REQ-020: `flush_i` SHALL clear all 16 valid bits in one cycle and force `pred_hit_o`=0 at the same edge, regardless of `stall_i`.
- REQ-021: When `flush_i` and `btb_update_i` are both high in one cycle, flush SHALL win and the update SHALL be dropped.
- REQ-022: When a lookup and an update to the same index occur in one cycle, the lookup SHALL see the pre-update entry unless `BTB_FWD_EN` is defined.
- REQ-023: Target storage has no arithmetic; it is stored verbatim at 32 bits.

Reset
- REQ-024: Reset SHALL asynchronously clear all valid bits and set `pred_hit_o`=0, `pred_target_o`=0 and `pred_pc_o`=0.
- REQ-025: Tag and target arrays are not reset.
- REQ-026: Reset asserted mid-stall or mid-update SHALL discard the pending operation; the first post-reset lookup misses.

Configuration
- REQ-027: With `BTB_FWD_EN` defined, a same-cycle update whose index and tag match the lookup PC SHALL be forwarded: the registered result is a hit with the update target.
- REQ-028: Without `BTB_FWD_EN`, no forwarding path exists and REQ-022 applies.
- REQ-029: Forwarding SHALL never override flush.

Structure
- REQ-030: Package `btb_pkg` SHALL hold `BTB_ENTRIES`, `BTB_IDX_W`=4, `BTB_TAG_W`=26 and typedef `btb_entry_t` {valid, tag, target}.
- REQ-031: Sub-module `ifu_btb_array` SHALL hold the entry storage, with one combinational read port, one write port, and flush-clear of the valid bits.
- REQ-032: `ifu_btb` SHALL hold the index/tag split, compare, forwarding and output registers.

Verification
- REQ-033: Update pc=0x0000_1004, target=0x0000_2000; next cycle look up 0x0000_1004 -> one cycle later `pred_hit_o`=1, `pred_target_o`=0x0000_2000, `pred_pc_o`=0x0000_1004.
- REQ-034: After REQ-033, look up 0x0000_1044 (same index 1, different tag) -> `pred_hit_o`=0, `pred_target_o`=0.
- REQ-035: Update 0x0000_1044 → 0x3000, then look up 0x0000_1004 -> miss (evicted); look up 0x0000_1044 -> hit with 0x3000.
- REQ-036: Assert `flush_i` and an update of 0x0000_1008 → 0x4000 together, then look up 0x0000_1008 -> miss; any earlier entries -> miss.
- REQ-037: Same-cycle update and lookup of 0x0000_100C → 0x5000 -> a hit with 0x5000 when `BTB_FWD_EN` is defined, a miss when it is not; the following lookup hits in both builds.
- REQ-038: Hit registered, then `stall_i`=1 for 3 cycles with a new lookup PC -> outputs unchanged; drop `rst_n` during the stall -> all outputs 0 immediately and the old PC misses after release.

Source files
------------

// File: rtl/ifu_btb_pkg.sv
// Shared BTB geometry, entry type and PC index/tag split helpers.
// Used by ifu_btb, its storage array and its interface.
package btb_pkg;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int BTB_ENTRIES     = 16;
  localparam int BTB_IDX_W       = 4;
  localparam int BTB_TAG_W       = 26;

  typedef logic [INST_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    addr_t                target;
  } btb_entry_t;

  // pc[1:0] never takes part in indexing or tagging
  function automatic logic [BTB_IDX_W-1:0] btb_idx(input addr_t pc);
    return pc[BTB_IDX_W+1:2];
  endfunction

  function automatic logic [BTB_TAG_W-1:0] btb_tag(input addr_t pc);
    return pc[INST_ADDR_WIDTH-1:BTB_IDX_W+2];
  endfunction
endpackage

// File: rtl/ifu_btb_if.sv
// Fetch/execute-facing signal bundle of the BTB.
// master = fetch + BRU side, slave = the BTB itself.
interface ifu_btb_if;
  import btb_pkg::*;

  logic  lookup_valid_i;
  addr_t lookup_pc_i;
  logic  stall_i;
  logic  flush_i;
  logic  btb_update_i;
  addr_t btb_update_pc_i;
  addr_t btb_update_target_i;
  logic  pred_hit_o;
  addr_t pred_target_o;
  addr_t pred_pc_o;

  modport master (
    output lookup_valid_i, lookup_pc_i, stall_i, flush_i,
           btb_update_i, btb_update_pc_i, btb_update_target_i,
    input  pred_hit_o, pred_target_o, pred_pc_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i, stall_i, flush_i,
           btb_update_i, btb_update_pc_i, btb_update_target_i,
    output pred_hit_o, pred_target_o, pred_pc_o
  );
endinterface

// File: rtl/ifu_btb_array.sv
// Direct-mapped BTB storage: one combinational read port, one write port,
// single-cycle flush of all valid bits. Tag/target arrays carry no reset.
module ifu_btb_array
  import btb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 we_i,
  input  logic [BTB_IDX_W-1:0] widx_i,
  input  logic [BTB_TAG_W-1:0] wtag_i,
  input  addr_t                wtarget_i,
  input  logic [BTB_IDX_W-1:0] ridx_i,
  output btb_entry_t           rentry_o
);
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] wsel;
  logic [BTB_TAG_W-1:0]   tag_mem    [BTB_ENTRIES];
  addr_t                  target_mem [BTB_ENTRIES];
  logic                   wr_en;

  // flush has priority: a same-cycle update is dropped entirely
  assign wr_en = we_i && !flush_i;

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_wsel
      assign wsel[gi] = wr_en && (widx_i == BTB_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_q | wsel;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[widx_i]    <= wtag_i;
      target_mem[widx_i] <= wtarget_i;
    end
  end

  assign rentry_o.valid  = valid_q[ridx_i];
  assign rentry_o.tag    = tag_mem[ridx_i];
  assign rentry_o.target = target_mem[ridx_i];
endmodule

// File: rtl/ifu_btb.sv
// JALR branch target buffer: 16-entry direct-mapped, 1-cycle registered lookup.
// Define BTB_FWD_EN to forward a same-cycle matching update into the lookup.
module ifu_btb
  import btb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  ifu_btb_if.slave  btb_if
);
  btb_entry_t           rd_entry;
  logic [BTB_TAG_W-1:0] lk_tag;
  logic                 lk_hit;
  addr_t                lk_target;
  logic                 hit_q, hit_d;
  addr_t                target_q, target_d;
  addr_t                pc_q, pc_d;

  assign lk_tag = btb_tag(btb_if.lookup_pc_i);

  ifu_btb_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (btb_if.flush_i),
    .we_i      (btb_if.btb_update_i),
    .widx_i    (btb_idx(btb_if.btb_update_pc_i)),
    .wtag_i    (btb_tag(btb_if.btb_update_pc_i)),
    .wtarget_i (btb_if.btb_update_target_i),
    .ridx_i    (btb_idx(btb_if.lookup_pc_i)),
    .rentry_o  (rd_entry)
  );

  always_comb begin
    lk_hit    = rd_entry.valid && (rd_entry.tag == lk_tag);
    lk_target = rd_entry.target;
`ifdef BTB_FWD_EN
    if (btb_if.btb_update_i
        && (btb_idx(btb_if.btb_update_pc_i) == btb_idx(btb_if.lookup_pc_i))
        && (btb_tag(btb_if.btb_update_pc_i) == lk_tag)) begin
      lk_hit    = 1'b1;
      lk_target = btb_if.btb_update_target_i;
    end
`endif
  end

  always_comb begin
    hit_d    = hit_q;
    target_d = target_q;
    pc_d     = pc_q;
    if (!btb_if.stall_i) begin
      if (btb_if.lookup_valid_i) begin
        hit_d    = lk_hit;
        target_d = lk_hit ? lk_target : '0;
        pc_d     = btb_if.lookup_pc_i;
      end else begin
        hit_d = 1'b0;
      end
    end
    // flush kills the prediction even while stalled, and beats forwarding
    if (btb_if.flush_i) begin
      hit_d = 1'b0;
      if (!btb_if.stall_i && btb_if.lookup_valid_i) begin
        target_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= 1'b0;
      target_q <= '0;
      pc_q     <= '0;
    end else begin
      hit_q    <= hit_d;
      target_q <= target_d;
      pc_q     <= pc_d;
    end
  end

  assign btb_if.pred_hit_o    = hit_q;
  assign btb_if.pred_target_o = target_q;
  assign btb_if.pred_pc_o     = pc_q;
endmodule

// File: tb/tb_ifu_btb.sv
// Scoreboard bench for ifu_btb: directed vectors push expected predictions,
// a negedge monitor pops and compares them.
module tb_ifu_btb;
  import btb_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    int          due;
    logic        hit;
    logic [31:0] tgt;
    logic [31:0] pc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  ifu_btb_if bif ();

  ifu_btb dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btb_if (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: compares the registered prediction against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due != cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: checked at cycle %0d required cycle %0d", e.name, cyc, e.due);
      end else begin
        $display("txn %-14s hit=%0b tgt=0x%08h pc=0x%08h", e.name,
                 bif.pred_hit_o, bif.pred_target_o, bif.pred_pc_o);
        chk({e.name, ".hit"}, {31'd0, bif.pred_hit_o}, {31'd0, e.hit});
        chk({e.name, ".tgt"}, bif.pred_target_o, e.tgt);
        chk({e.name, ".pc"},  bif.pred_pc_o, e.pc);
      end
    end
  end

  task automatic drive(input logic lv, input logic [31:0] pc, input logic st,
                       input logic fl, input logic up, input logic [31:0] upc,
                       input logic [31:0] utgt);
    bif.lookup_valid_i      = lv;
    bif.lookup_pc_i         = pc;
    bif.stall_i             = st;
    bif.flush_i             = fl;
    bif.btb_update_i        = up;
    bif.btb_update_pc_i     = upc;
    bif.btb_update_target_i = utgt;
  endtask

  task automatic vec(input string nm, input logic lv, input logic [31:0] pc,
                     input logic st, input logic fl, input logic up,
                     input logic [31:0] upc, input logic [31:0] utgt,
                     input logic ehit, input logic [31:0] etgt, input logic [31:0] epc);
    exp_t e;
    drive(lv, pc, st, fl, up, upc, utgt);
    e.due  = cyc + 1;
    e.hit  = ehit;
    e.tgt  = etgt;
    e.pc   = epc;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fwd_hit;
    logic [31:0] fwd_tgt;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.hit", {31'd0, bif.pred_hit_o}, 32'd0);
    chk("reset.tgt", bif.pred_target_o, 32'd0);
    chk("reset.pc",  bif.pred_pc_o, 32'd0);
    rst_n = 1'b1;

`ifdef BTB_FWD_EN
    fwd_hit = 1'b1;
    fwd_tgt = 32'h0000_5000;
`else
    fwd_hit = 1'b0;
    fwd_tgt = 32'h0;
`endif

    //   name             lv  pc            st fl up  upc           utgt           hit tgt            pc
    vec("upd_1004",      0, 32'h0,        0, 0, 1, 32'h0000_1004, 32'h0000_2000, 0, 32'h0,         32'h0);
    vec("lk_1004_hit",   1, 32'h0000_1004,0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_2000, 32'h0000_1004);
    vec("lk_1044_alias", 1, 32'h0000_1044,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1044);
    vec("upd_1044",      0, 32'h0,        0, 0, 1, 32'h0000_1044, 32'h0000_3000, 0, 32'h0,         32'h0000_1044);
    vec("lk_1004_evict", 1, 32'h0000_1004,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1004);
    vec("lk_1044_hit",   1, 32'h0000_1044,0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_3000, 32'h0000_1044);
    vec("flush_upd",     0, 32'h0,        0, 1, 1, 32'h0000_1008, 32'h0000_4000, 0, 32'h0000_3000, 32'h0000_1044);
    vec("lk_1008_drop",  1, 32'h0000_1008,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1008);
    vec("lk_1044_flush", 1, 32'h0000_1044,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1044);
    vec("same_cyc_100c", 1, 32'h0000_100C,0, 0, 1, 32'h0000_100C, 32'h0000_5000, fwd_hit, fwd_tgt, 32'h0000_100C);
    vec("lk_100c_hit",   1, 32'h0000_100C,0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_5000, 32'h0000_100C);
    vec("lk_100f_lowbit",1, 32'h0000_100F,0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_5000, 32'h0000_100F);
    vec("stall_1",       1, 32'h0000_1044,1, 0, 1, 32'h0000_1010, 32'h0000_6000, 1, 32'h0000_5000, 32'h0000_100F);
    vec("stall_2",       1, 32'h0000_1044,1, 0, 0, 32'h0,         32'h0,         1, 32'h0000_5000, 32'h0000_100F);
    vec("stall_3",       1, 32'h0000_1044,1, 0, 0, 32'h0,         32'h0,         1, 32'h0000_5000, 32'h0000_100F);

    // reset dropped mid-stall with an update pending
    drive(1'b1, 32'h0000_1044, 1'b1, 1'b0, 1'b1, 32'h0000_1014, 32'h0000_7000);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall.hit", {31'd0, bif.pred_hit_o}, 32'd0);
    chk("rst_stall.tgt", bif.pred_target_o, 32'd0);
    chk("rst_stall.pc",  bif.pred_pc_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vec("post_rst_100f", 1, 32'h0000_100F,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_100F);
    vec("post_rst_1014", 1, 32'h0000_1014,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1014);
    vec("post_rst_1010", 1, 32'h0000_1010,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1010);
    vec("stall_upd_1018",1, 32'h0000_1018,1, 0, 1, 32'h0000_1018, 32'h0000_8000, 0, 32'h0,         32'h0000_1010);
    vec("lk_1018_hit",   1, 32'h0000_1018,0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_8000, 32'h0000_1018);
    vec("stall_flush",   1, 32'h0000_1004,1, 1, 0, 32'h0,         32'h0,         0, 32'h0000_8000, 32'h0000_1018);
    vec("lk_1018_miss",  1, 32'h0000_1018,0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_1018);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
